decode_fetch_queue: RTL and testbench
=====================================

Name: decode_fetch_queue

Overview:
- Parametrised successor to the IF/ID decode pipeline register: a DEPTH-entry instruction/PC queue plus one decode output register.
- Decouples fetch from decode with a valid/ready handshake, replacing the single stall-only register.
- Sits between the fetch stage (instr, PCF) and the decode stage (instrD, PCD).
- Supports stall, flush and bubble insertion (NOP output with validD=0).

Parameters:
DPW, 32, data/PC width in bits
DEPTH, 4, FIFO entries behind the output register; power of 2, >=2
NOP_INSTR, 32'h0000_0013, instruction driven on instrD when validD=0 (addi x0,x0,0); width DPW

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
validF  in  1  fetch presents a valid instr/PCF this cycle
instr  in  DPW  fetched instruction
PCF  in  DPW  PC of fetched instruction
readyF  out  1  queue can accept a push this cycle
stallD  in  1  decode holds its current instruction
FlashD  in  1  flush: discard output register and all queued entries
instrD  out  DPW  instruction presented to decode
PCD  out  DPW  PC presented to decode
validD  out  1  instrD/PCD hold a real instruction
countD  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - instrD=NOP_INSTR, PCD=0, validD=0, countD=0.
  - Read/write pointers = 0.
  - readyF reads 1 in the cycle after reset.
  - rst overrides all other inputs.
- readyF = (countD < DEPTH):
  - Purely from registered count; no combinational path from stallD or FlashD.
  - push = validF & readyF & !FlashD.
  - validF with readyF=0 is not accepted; fetch must hold its data.
- Advance: adv = !stallD.
- Flush (FlashD=1, rst=0):
  - Next state: instrD=NOP_INSTR, PCD=0, validD=0, countD=0, rd_ptr=wr_ptr.
  - A same-cycle push is dropped.
  - Flush takes priority over stallD.
- Output register update when !FlashD:
  - stallD=1: instrD/PCD/validD hold, even when validD=0.
  - adv and countD>0: load FIFO head; rd_ptr+1; countD-1, plus 1 if a push also occurs.
  - adv, countD=0, push: the pushed entry loads directly into the output register, validD=1. FIFO is untouched. Latency is 1 cycle from push to validD.
  - adv, countD=0, no push: instrD=NOP_INSTR, PCD=0, validD=0 (bubble).
- FIFO write when !FlashD:
  - push goes into the FIFO unless it bypasses into the output register as described above.
  - A FIFO write stores {instr,PCF} at wr_ptr; wr_ptr+1.
- Simultaneous push and pop at countD=DEPTH cannot occur (readyF=0). At 0<countD<DEPTH, push+pop leaves countD unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by countD, not pointer comparison.
- Ordering:
  - Strict FIFO; instructions reach decode in push order.
  - No entry is duplicated or lost except by flush or reset.
- Total capacity is DEPTH+1 (FIFO plus output register).
- Invariant: validD=0 implies countD=0 while stallD=0.

Test Plan:
1. Reset:
   - Assert rst for 2 cycles with validF=1.
   - Required: instrD=32'h00000013, PCD=0, validD=0, countD=0, readyF=1.
   - No push is accepted during reset.
2. Pass-through:
   - stallD=0; push instr=32'h00500093, PCF=32'h100.
   - Required: next cycle instrD=32'h00500093, PCD=32'h100, validD=1, countD=0.
   - Following cycle with no push: NOP, validD=0.
3. Fill under stall:
   - With validD=1, hold stallD=1 and push 5 instrs (PC 0x104..0x114).
   - Required: countD reaches 4, readyF=0, the 5th push is not accepted.
   - Release stallD: PCD sequence 0x104,0x108,0x10C,0x110, then the held 0x114 push enters.
4. Flush mid-fill:
   - countD=3, validD=1; assert FlashD together with stallD=1 and validF=1.
   - Required: next cycle validD=0, instrD=NOP, PCD=0, countD=0, readyF=1.
   - The pushed instruction is never observed on PCD.
5. Wrap-around:
   - Stream 3*DEPTH+1 pushes with stallD toggling pseudo-randomly.
   - Required: PCD order is strictly increasing by 4, with no gaps or duplicates.
   - countD always equals pushes minus pops.
6. Push+pop steady state:
   - countD=2; push every cycle with stallD=0 for 8 cycles.
   - Required: countD stays 2, validD=1 every cycle, PCD increments by 4 each cycle.

Source files
------------

// File: rtl/decode_fetch_queue.sv
// decode_fetch_queue: fetch-to-decode instruction/PC queue.
// A DEPTH-entry FIFO sits behind a single decode output register. When the
// FIFO is empty and decode advances, a fresh push bypasses straight into the
// output register so the empty-queue latency stays at one cycle.
module decode_fetch_queue #(
    parameter int             DPW       = 32,
    parameter int             DEPTH     = 4,
    parameter logic [DPW-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         validF,
    input  logic [DPW-1:0]               instr,
    input  logic [DPW-1:0]               PCF,
    output logic                         readyF,
    input  logic                         stallD,
    input  logic                         FlashD,
    output logic [DPW-1:0]               instrD,
    output logic [DPW-1:0]               PCD,
    output logic                         validD,
    output logic [$clog2(DEPTH+1)-1:0]   countD
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [2*DPW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             adv;
    logic             fifo_empty;
    logic             bypass;
    logic             fifo_wr;
    logic             pop;

    // readyF depends only on the registered occupancy, so fetch never sees
    // a combinational path from stallD or FlashD.
    assign readyF     = (count < CW'(DEPTH));
    assign countD     = count;
    assign push       = validF & readyF & ~FlashD;
    assign adv        = ~stallD;
    assign fifo_empty = (count == '0);
    // An empty FIFO with decode advancing hands the push straight to decode.
    assign bypass     = push & adv & fifo_empty;
    assign fifo_wr    = push & ~bypass;
    assign pop        = adv & ~fifo_empty & ~FlashD;

    // Pointer and occupancy bookkeeping; flush drops everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FlashD) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({fifo_wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; entries are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= {instr, PCF};
        end
    end

    // Decode output register: hold on stall, else load head, bypass, or bubble.
    always_ff @(posedge clk) begin
        if (rst || FlashD) begin
            instrD <= NOP_INSTR;
            PCD    <= '0;
            validD <= 1'b0;
        end else if (adv) begin
            if (!fifo_empty) begin
                {instrD, PCD} <= mem[rd_ptr];
                validD        <= 1'b1;
            end else if (push) begin
                instrD <= instr;
                PCD    <= PCF;
                validD <= 1'b1;
            end else begin
                instrD <= NOP_INSTR;
                PCD    <= '0;
                validD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Testbench for decode_fetch_queue: scenario tasks plus a scoreboard monitor
// that tracks every accepted push and checks what reaches decode.
module tb_decode_fetch_queue;

    localparam int DPW   = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        validF;
    logic [31:0] instr;
    logic [31:0] PCF;
    logic        readyF;
    logic        stallD;
    logic        FlashD;
    logic [31:0] instrD;
    logic [31:0] PCD;
    logic        validD;
    logic [$clog2(DEPTH+1)-1:0] countD;

    int n_assert;
    int n_fail;

    logic [63:0] sb[$];
    logic [31:0] exp_i;
    logic [31:0] exp_p;
    logic        exp_v;
    logic        mon_en;

    decode_fetch_queue #(
        .DPW(DPW),
        .DEPTH(DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .validF(validF),
        .instr(instr),
        .PCF(PCF),
        .readyF(readyF),
        .stallD(stallD),
        .FlashD(FlashD),
        .instrD(instrD),
        .PCD(PCD),
        .validD(validD),
        .countD(countD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: queue of accepted-but-not-yet-decoded entries, checked every edge.
    always @(posedge clk) begin
        logic        rdy;
        logic [63:0] e;
        if (rst) begin
            sb.delete();
            exp_i  = NOP;
            exp_p  = '0;
            exp_v  = 1'b0;
            mon_en = 1'b1;
        end else if (mon_en) begin
            rdy = (sb.size() < DEPTH);
            n_assert++;
            if (readyF !== rdy) begin
                n_fail++;
                $display("FAIL mon_readyF: got %b want %b", readyF, rdy);
            end
            if (FlashD) begin
                sb.delete();
                exp_i = NOP;
                exp_p = '0;
                exp_v = 1'b0;
            end else begin
                if (validF && rdy) sb.push_back({instr, PCF});
                if (!stallD) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        exp_i = e[63:32];
                        exp_p = e[31:0];
                        exp_v = 1'b1;
                    end else begin
                        exp_i = NOP;
                        exp_p = '0;
                        exp_v = 1'b0;
                    end
                end
            end
        end
        if (mon_en) begin
            #1;
            n_assert++;
            if (instrD !== exp_i || PCD !== exp_p || validD !== exp_v) begin
                n_fail++;
                $display("FAIL mon_out: got instr=%h pc=%h v=%b want instr=%h pc=%h v=%b",
                         instrD, PCD, validD, exp_i, exp_p, exp_v);
            end
            n_assert++;
            if (countD !== sb.size()) begin
                n_fail++;
                $display("FAIL mon_count: got %0d want %0d", countD, sb.size());
            end
        end
    end

    task automatic tick(input logic vf, input logic [31:0] pc, input logic st, input logic fl);
        validF = vf;
        PCF    = pc;
        instr  = pc ^ 32'hA5A5_0000;
        stallD = st;
        FlashD = fl;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0044, 1'b0, 1'b0);
        n_assert++;
        if (instrD !== 32'h0000_0013 || PCD !== 32'h0 || validD !== 1'b0 || countD !== 0) begin
            n_fail++;
            $display("FAIL reset_state: got instr=%h pc=%h v=%b cnt=%0d want 00000013/0/0/0",
                     instrD, PCD, validD, countD);
        end
        rst = 1'b0;
        n_assert++;
        if (readyF !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", readyF);
        end
    endtask

    task automatic test_pass_through();
        validF = 1'b1;
        PCF    = 32'h100;
        instr  = 32'h0050_0093;
        stallD = 1'b0;
        FlashD = 1'b0;
        @(negedge clk);
        n_assert++;
        if (instrD !== 32'h0050_0093 || PCD !== 32'h100 || validD !== 1'b1 || countD !== 0) begin
            n_fail++;
            $display("FAIL pass_load: got instr=%h pc=%h v=%b cnt=%0d want 00500093/100/1/0",
                     instrD, PCD, validD, countD);
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        n_assert++;
        if (instrD !== NOP || PCD !== 32'h0 || validD !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_bubble: got instr=%h pc=%h v=%b want NOP/0/0", instrD, PCD, validD);
        end
    endtask

    task automatic test_fill_stall();
        logic r;
        logic acc;
        tick(1'b1, 32'h100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 32'h104 + 32'(4 * i), 1'b1, 1'b0);
            n_assert++;
            if (countD !== i + 1) begin
                n_fail++;
                $display("FAIL fill_count: got %0d want %0d", countD, i + 1);
            end
        end
        n_assert++;
        if (readyF !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: readyF got %b want 0", readyF);
        end
        tick(1'b1, 32'h114, 1'b1, 1'b0);
        n_assert++;
        if (countD !== 4 || PCD !== 32'h100 || validD !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_reject: got cnt=%0d pc=%h v=%b want 4/100/1", countD, PCD, validD);
        end
        acc = 1'b0;
        for (int j = 0; j < 5; j++) begin
            r = readyF;
            tick(!acc, 32'h114, 1'b0, 1'b0);
            if (!acc && r) acc = 1'b1;
            n_assert++;
            if (PCD !== 32'h104 + 32'(4 * j) || validD !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_seq: got pc=%h v=%b want %h/1", PCD, validD, 32'h104 + 32'(4 * j));
            end
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        n_assert++;
        if (validD !== 1'b0 || countD !== 0) begin
            n_fail++;
            $display("FAIL drain_end: got v=%b cnt=%0d want 0/0", validD, countD);
        end
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h200, 1'b0, 1'b0);
        tick(1'b1, 32'h204, 1'b1, 1'b0);
        tick(1'b1, 32'h208, 1'b1, 1'b0);
        tick(1'b1, 32'h20C, 1'b1, 1'b0);
        n_assert++;
        if (countD !== 3 || validD !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got cnt=%0d v=%b want 3/1", countD, validD);
        end
        tick(1'b1, 32'h210, 1'b1, 1'b1);
        n_assert++;
        if (validD !== 1'b0 || instrD !== NOP || PCD !== 32'h0 || countD !== 0 || readyF !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: got v=%b instr=%h pc=%h cnt=%0d rdy=%b want 0/NOP/0/0/1",
                     validD, instrD, PCD, countD, readyF);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b0);
            n_assert++;
            if (PCD === 32'h210 || validD !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_drop: got pc=%h v=%b want 0/0", PCD, validD);
            end
        end
    endtask

    task automatic test_wrap();
        int k;
        int nout;
        int iter;
        logic r;
        logic st;
        k = 0;
        nout = 0;
        iter = 0;
        while ((k < 3 * DEPTH + 1 || nout < k) && iter < 200) begin
            r  = readyF;
            st = 1'($urandom_range(0, 1));
            if (k < 3 * DEPTH + 1) begin
                tick(1'b1, 32'h300 + 32'(4 * k), st, 1'b0);
                if (r) k++;
            end else begin
                tick(1'b0, 32'h0, st, 1'b0);
            end
            if (!st && validD === 1'b1) begin
                n_assert++;
                if (PCD !== 32'h300 + 32'(4 * nout)) begin
                    n_fail++;
                    $display("FAIL wrap_order: got %h want %h", PCD, 32'h300 + 32'(4 * nout));
                end
                nout++;
            end
            iter++;
        end
        n_assert++;
        if (nout !== 3 * DEPTH + 1) begin
            n_fail++;
            $display("FAIL wrap_total: got %0d outputs want %0d", nout, 3 * DEPTH + 1);
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_steady();
        tick(1'b1, 32'h400, 1'b0, 1'b0);
        tick(1'b1, 32'h404, 1'b1, 1'b0);
        tick(1'b1, 32'h408, 1'b1, 1'b0);
        n_assert++;
        if (countD !== 2 || validD !== 1'b1 || PCD !== 32'h400) begin
            n_fail++;
            $display("FAIL steady_setup: got cnt=%0d v=%b pc=%h want 2/1/400", countD, validD, PCD);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 32'h40C + 32'(4 * i), 1'b0, 1'b0);
            n_assert++;
            if (countD !== 2 || validD !== 1'b1 || PCD !== 32'h404 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL steady_cycle: got cnt=%0d v=%b pc=%h want 2/1/%h",
                         countD, validD, PCD, 32'h404 + 32'(4 * i));
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
        n_assert++;
        if (validD !== 1'b0 || countD !== 0) begin
            n_fail++;
            $display("FAIL steady_drain: got v=%b cnt=%0d want 0/0", validD, countD);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        validF   = 1'b0;
        instr    = '0;
        PCF      = '0;
        stallD   = 1'b0;
        FlashD   = 1'b0;
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_flush();
        test_wrap();
        test_steady();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
